game_step_scheduler: RTL and testbench
======================================

GAME_STEP_SCHEDULER -- requirements
Module: game_step_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25_000_000, meaning clk cycles per game step (min 4).
REQ-002 SHALL have parameter AI_TIMEOUT, default 1024, meaning max clk cycles to wait for ai_ack.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins or restarts a game.
REQ-006 SHALL have port pause  input  1  one-cycle pulse; toggles pause.
REQ-007 SHALL have port ai_mode  input  1  1 = AI steers, 0 = keyboard steers.
REQ-008 SHALL have ports key_valid, key_dir  input  1, 2  keyboard direction strobe and value (0 up, 1 right, 2 down, 3 left).
REQ-009 SHALL have ports ai_req, ai_ack, ai_dir  output 1, input 1, input 2  AI move handshake.
REQ-010 SHALL have ports update_done, game_over  input  1, 1  datapath step complete, collision flag.
REQ-011 SHALL have ports step_go, step_dir  output  1, 2  one-cycle step command and its direction.
REQ-012 SHALL have ports running, paused, over, ai_timeout  output  1 each  status; ai_timeout is a one-cycle pulse.
REQ-013 SHALL have port step_cnt  output  16  steps committed since last start.

Function
REQ-014 SHALL implement states IDLE, WAIT_TICK, PAUSED, AI_REQ, STEP, WAIT_DONE, OVER.
REQ-015 IDLE/OVER: start -> WAIT_TICK; step_cnt cleared, cur_dir = right (1), pending key cleared.
REQ-016 WAIT_TICK: tick counter cleared on entry, increments each cycle; at count TICK_DIV-1 -> AI_REQ if ai_mode=1, else STEP.
REQ-017 pause in WAIT_TICK -> PAUSED with counter frozen; pause in PAUSED -> WAIT_TICK, counter resumes from held value; pause in any other state ignored.
REQ-018 AI_REQ: ai_req high every cycle in state; ai_ack with ai_dir -> STEP using ai_dir, except ai_dir == cur_dir^2 (reversal) -> STEP using cur_dir.
REQ-019 AI_REQ: AI_TIMEOUT cycles without ai_ack -> STEP using cur_dir, ai_timeout pulsed one cycle.
REQ-020 Keyboard: key_valid with key_dir != cur_dir^2 SHALL load pending register (latest wins), in any state except IDLE/OVER; reversals discarded.
REQ-021 STEP (manual): direction = pending if valid else cur_dir; pending cleared; key_valid in same cycle checked against new direction and kept for next step.
REQ-022 STEP: step_go=1, step_dir=direction for exactly one cycle; cur_dir updated; step_cnt += 1, wrapping 0xFFFF -> 0; -> WAIT_DONE.
REQ-023 WAIT_DONE: update_done with game_over=1 -> OVER; update_done with game_over=0 -> WAIT_TICK.
REQ-024 start in any state except IDLE/OVER ignored.
REQ-025 running=1 in all states except IDLE/OVER; paused=1 only in PAUSED; over=1 only in OVER.
REQ-026 ai_req, step_go, ai_timeout SHALL be registered outputs.

Reset
REQ-027 rst_n low SHALL force IDLE, tick/timeout counters 0, step_cnt 0, cur_dir 1, pending cleared, all outputs 0 except step_dir=1, regardless of handshake in progress.
REQ-028 After rst_n deasserts, no step_go until a start pulse.

Structure
REQ-029 Direction encodings, opposite-direction function and state enum SHALL live in shared package game_pkg.
REQ-030 Tick counter SHALL be sub-module step_tick_gen (enable, clear, tick out).

Verification (TICK_DIV=8, AI_TIMEOUT=5)
REQ-031 start, no keys -> step_go once per 8 WAIT_TICK cycles + handshake, step_dir=1, step_cnt 1,2,3.
REQ-032 cur_dir=1, key_dir=3 then key_dir=0 -> next step_dir=0; lone key_dir=3 -> step_dir=1.
REQ-033 ai_mode=1, ai_ack 2 cycles after ai_req with ai_dir=2 -> step_dir=2; no ack -> step_dir=cur_dir, ai_timeout pulse after 5 cycles.
REQ-034 pause at count 4, hold 20 cycles, pause -> step_go exactly 4 cycles after resume; paused=1 throughout.
REQ-035 update_done with game_over=1 -> over=1, no further step_go; start -> step_cnt=0, step_dir=1.
REQ-036 rst_n low during AI_REQ -> ai_req=0 same cycle, state IDLE, step_cnt=0.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Package    : game_pkg
// Purpose    : Shared types for the game step scheduler. Holds the direction
//              encoding, the scheduler state enum and the opposite-direction
//              helper used to reject 180-degree reversals.
// Revision   : 1.0  initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_PAUSED    = 3'd2,
        S_AI_REQ    = 3'd3,
        S_STEP      = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_OVER      = 3'd6
    } state_e;

    // Opposite directions differ only in bit 1 (up<->down, right<->left).
    function automatic dir_e opposite_dir(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_tick_gen.sv
`default_nettype none
// ============================================================================
// Module     : step_tick_gen
// Purpose    : Game-step tick counter. Counts enabled cycles and flags the
//              cycle in which the count reaches TICK_DIV-1. Holding enable_i
//              low freezes the count; clear_i forces it back to zero.
// Ports      : clk       - clock, rising edge
//              rst_n     - asynchronous active-low reset
//              enable_i  - advance the count this cycle
//              clear_i   - force count to zero (has priority over enable_i)
//              tick_o    - high in the enabled cycle where count == TICK_DIV-1
// Revision   : 1.0  initial release
// ============================================================================
module step_tick_gen #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : game_step_scheduler
// Purpose    : Paces a grid game. Every TICK_DIV cycles it issues one step
//              command whose direction comes from the keyboard (pending key)
//              or from an AI engine via a request/ack handshake with timeout,
//              then waits for the datapath to report the step complete.
// Ports      : clk, rst_n                 - clock / async active-low reset
//              start, pause               - game control pulses
//              ai_mode                    - 1 = AI steers, 0 = keyboard
//              key_valid, key_dir         - keyboard direction strobe
//              ai_req / ai_ack, ai_dir    - AI move handshake
//              update_done, game_over     - datapath step result
//              step_go, step_dir          - one-cycle step command
//              running, paused, over      - status
//              ai_timeout                 - one-cycle pulse on AI timeout
//              step_cnt                   - steps since last start
// Revision   : 1.0  initial release
// ============================================================================
module game_step_scheduler
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned AI_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        ai_mode,
    input  logic        key_valid,
    input  logic [1:0]  key_dir,
    output logic        ai_req,
    input  logic        ai_ack,
    input  logic [1:0]  ai_dir,
    input  logic        update_done,
    input  logic        game_over,
    output logic        step_go,
    output logic [1:0]  step_dir,
    output logic        running,
    output logic        paused,
    output logic        over,
    output logic        ai_timeout,
    output logic [15:0] step_cnt
);

    localparam int unsigned AI_W = $clog2(AI_TIMEOUT) + 1;
    localparam logic [AI_W-1:0] AI_LAST = AI_W'(AI_TIMEOUT - 1);

    state_e          state_q,      state_d;
    dir_e            cur_dir_q,    cur_dir_d;
    dir_e            pend_dir_q,   pend_dir_d;
    logic            pend_vld_q,   pend_vld_d;
    dir_e            step_dir_q,   step_dir_d;
    logic            step_go_q,    step_go_d;
    logic            ai_req_q,     ai_req_d;
    logic            ai_tmo_q,     ai_tmo_d;
    logic [15:0]     step_cnt_q,   step_cnt_d;
    logic [AI_W-1:0] ai_cnt_q,     ai_cnt_d;

    logic tick;
    logic tick_en;
    logic tick_clr;
    logic in_game;
    dir_e key_d;
    dir_e ai_d;
    dir_e new_dir;
    logic commit;

    assign key_d   = dir_e'(key_dir);
    assign ai_d    = dir_e'(ai_dir);
    assign in_game = (state_q != S_IDLE) && (state_q != S_OVER);

    // Counter only advances in WAIT_TICK and freezes in the pause cycle itself,
    // so a pause on the terminal count suppresses the tick. It is held at zero
    // everywhere outside WAIT_TICK/PAUSED, which gives "cleared on entry".
    assign tick_en  = (state_q == S_WAIT_TICK) && !pause;
    assign tick_clr = (state_q != S_WAIT_TICK) && (state_q != S_PAUSED);

    step_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (tick_en),
        .clear_i  (tick_clr),
        .tick_o   (tick)
    );

    always_comb begin
        state_d    = state_q;
        cur_dir_d  = cur_dir_q;
        pend_dir_d = pend_dir_q;
        pend_vld_d = pend_vld_q;
        step_dir_d = step_dir_q;
        step_cnt_d = step_cnt_q;
        step_go_d  = 1'b0;
        ai_tmo_d   = 1'b0;
        new_dir    = cur_dir_q;
        commit     = 1'b0;

        // Latest non-reversing key wins while a game is in progress.
        if (in_game && key_valid && (key_d != opposite_dir(cur_dir_q))) begin
            pend_vld_d = 1'b1;
            pend_dir_d = key_d;
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d    = S_WAIT_TICK;
                    step_cnt_d = '0;
                    cur_dir_d  = DIR_RIGHT;
                    step_dir_d = DIR_RIGHT;
                    pend_vld_d = 1'b0;
                end
            end
            S_WAIT_TICK: begin
                if (pause) begin
                    state_d = S_PAUSED;
                end else if (tick) begin
                    if (ai_mode) begin
                        state_d = S_AI_REQ;
                    end else begin
                        // The commit cycle is the step decision point: the
                        // pending key is consumed, and a key arriving now is
                        // judged against the new direction for the next step.
                        commit     = 1'b1;
                        new_dir    = pend_vld_q ? pend_dir_q : cur_dir_q;
                        pend_dir_d = key_d;
                        pend_vld_d = key_valid && (key_d != opposite_dir(new_dir));
                    end
                end
            end
            S_PAUSED: begin
                if (pause) begin
                    state_d = S_WAIT_TICK;
                end
            end
            S_AI_REQ: begin
                if (ai_ack) begin
                    commit  = 1'b1;
                    new_dir = (ai_d == opposite_dir(cur_dir_q)) ? cur_dir_q : ai_d;
                end else if (ai_cnt_q == AI_LAST) begin
                    commit   = 1'b1;
                    new_dir  = cur_dir_q;
                    ai_tmo_d = 1'b1;
                end
            end
            S_STEP: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (update_done) begin
                    state_d = game_over ? S_OVER : S_WAIT_TICK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            state_d    = S_STEP;
            step_go_d  = 1'b1;
            step_dir_d = new_dir;
            cur_dir_d  = new_dir;
            step_cnt_d = step_cnt_q + 16'd1;
        end

        ai_req_d = (state_d == S_AI_REQ);
        ai_cnt_d = (state_q == S_AI_REQ) ? ai_cnt_q + AI_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_dir_q  <= DIR_RIGHT;
            pend_dir_q <= DIR_RIGHT;
            pend_vld_q <= 1'b0;
            step_dir_q <= DIR_RIGHT;
            step_go_q  <= 1'b0;
            ai_req_q   <= 1'b0;
            ai_tmo_q   <= 1'b0;
            step_cnt_q <= '0;
            ai_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_dir_q  <= cur_dir_d;
            pend_dir_q <= pend_dir_d;
            pend_vld_q <= pend_vld_d;
            step_dir_q <= step_dir_d;
            step_go_q  <= step_go_d;
            ai_req_q   <= ai_req_d;
            ai_tmo_q   <= ai_tmo_d;
            step_cnt_q <= step_cnt_d;
            ai_cnt_q   <= ai_cnt_d;
        end
    end

    assign ai_req     = ai_req_q;
    assign step_go    = step_go_q;
    assign step_dir   = step_dir_q;
    assign ai_timeout = ai_tmo_q;
    assign step_cnt   = step_cnt_q;
    assign running    = in_game;
    assign paused     = (state_q == S_PAUSED);
    assign over       = (state_q == S_OVER);

endmodule
`default_nettype wire

// File: tb/tb_game_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : tb_game_step_scheduler
// Purpose    : Directed self-checking bench for game_step_scheduler with
//              TICK_DIV=8, AI_TIMEOUT=5. Inputs change 1 time unit after the
//              rising edge; outputs are sampled at the same point.
// Revision   : 1.0  initial release
// ============================================================================
module tb_game_step_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, pause, ai_mode, key_valid;
    logic [1:0]  key_dir;
    logic        ai_req, ai_ack;
    logic [1:0]  ai_dir;
    logic        update_done, game_over;
    logic        step_go;
    logic [1:0]  step_dir;
    logic        running, paused, over, ai_timeout;
    logic [15:0] step_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_step_scheduler #(
        .TICK_DIV   (8),
        .AI_TIMEOUT (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pause       (pause),
        .ai_mode     (ai_mode),
        .key_valid   (key_valid),
        .key_dir     (key_dir),
        .ai_req      (ai_req),
        .ai_ack      (ai_ack),
        .ai_dir      (ai_dir),
        .update_done (update_done),
        .game_over   (game_over),
        .step_go     (step_go),
        .step_dir    (step_dir),
        .running     (running),
        .paused      (paused),
        .over        (over),
        .ai_timeout  (ai_timeout),
        .step_cnt    (step_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Cycles until step_go shows; bounded so a stuck design still reaches the summary.
    task automatic wait_step(input string tag, input int exp_n);
        int n = 0;
        while (!step_go && n < 100) begin
            cyc();
            n++;
        end
        check(tag, n, exp_n);
    endtask

    task automatic wait_ai(input string tag, input int exp_n);
        int n = 0;
        while (!ai_req && n < 100) begin
            cyc();
            n++;
        end
        check(tag, n, exp_n);
    endtask

    // Called in the STEP cycle: moves to WAIT_DONE and reports the step done.
    task automatic finish_step(input logic go_over);
        cyc();
        check("step_go_one_cycle", step_go, 1'b0);
        check("ai_timeout_idle", ai_timeout, 1'b0);
        update_done = 1'b1;
        game_over   = go_over;
        cyc();
        update_done = 1'b0;
        game_over   = 1'b0;
    endtask

    task automatic no_go_for(input string tag, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            cyc();
            if (step_go) seen = 1'b1;
        end
        check(tag, seen, 1'b0);
    endtask

    initial begin
        logic seen_go;
        logic all_p;
        int   n;

        rst_n = 1'b0; start = 1'b0; pause = 1'b0; ai_mode = 1'b0;
        key_valid = 1'b0; key_dir = 2'd0; ai_ack = 1'b0; ai_dir = 2'd0;
        update_done = 1'b0; game_over = 1'b0;
        cyc(); cyc();

        // Reset state
        check("rst_step_go", step_go, 1'b0);
        check("rst_ai_req", ai_req, 1'b0);
        check("rst_ai_timeout", ai_timeout, 1'b0);
        check("rst_status", {running, paused, over}, 3'b000);
        check("rst_step_dir", step_dir, 2'd1);
        check("rst_step_cnt", step_cnt, 16'd0);
        rst_n = 1'b1;
        no_go_for("no_go_before_start", 20);

        // Free-running manual steps, no keys
        start = 1'b1; cyc(); start = 1'b0;
        check("running_after_start", running, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            wait_step("tick_period", 8);
            check("plain_dir", step_dir, 2'd1);
            check("plain_cnt", step_cnt, i);
            finish_step(1'b0);
        end

        // Lone reversal key is discarded
        key_valid = 1'b1; key_dir = 2'd3; cyc(); key_valid = 1'b0;
        wait_step("lone_rev_wait", 7);
        check("lone_rev_dir", step_dir, 2'd1);
        check("lone_rev_cnt", step_cnt, 16'd4);
        finish_step(1'b0);

        // Reversal then valid key: valid one steers
        key_valid = 1'b1; key_dir = 2'd3; cyc();
        key_dir = 2'd0; cyc(); key_valid = 1'b0;
        wait_step("rev_then_up_wait", 6);
        check("rev_then_up_dir", step_dir, 2'd0);
        check("rev_then_up_cnt", step_cnt, 16'd5);
        finish_step(1'b0);

        // Now heading up: down is a reversal
        key_valid = 1'b1; key_dir = 2'd2; cyc(); key_valid = 1'b0;
        wait_step("down_rev_wait", 7);
        check("down_rev_dir", step_dir, 2'd0);
        finish_step(1'b0);

        // Key in the commit cycle applies to the following step
        repeat (7) cyc();
        key_valid = 1'b1; key_dir = 2'd1; cyc(); key_valid = 1'b0;
        check("commit_key_go", step_go, 1'b1);
        check("commit_key_dir", step_dir, 2'd0);
        check("commit_key_cnt", step_cnt, 16'd7);
        finish_step(1'b0);
        wait_step("deferred_key_wait", 8);
        check("deferred_key_dir", step_dir, 2'd1);
        finish_step(1'b0);

        // Pause at count 4 for 20+ cycles, then resume
        repeat (4) cyc();
        pause = 1'b1; cyc(); pause = 1'b0;
        check("paused_set", paused, 1'b1);
        seen_go = 1'b0; all_p = 1'b1;
        repeat (20) begin
            cyc();
            if (step_go) seen_go = 1'b1;
            if (!paused) all_p = 1'b0;
        end
        check("paused_no_go", seen_go, 1'b0);
        check("paused_held", all_p, 1'b1);
        pause = 1'b1; cyc(); pause = 1'b0;
        check("resume_paused_clr", paused, 1'b0);
        wait_step("resume_to_go", 4);
        check("resume_cnt", step_cnt, 16'd9);
        finish_step(1'b0);

        // Game over then restart
        wait_step("pre_over_wait", 8);
        finish_step(1'b1);
        check("over_flag", over, 1'b1);
        check("over_not_running", running, 1'b0);
        no_go_for("no_go_when_over", 20);
        start = 1'b1; cyc(); start = 1'b0;
        check("restart_over_clr", over, 1'b0);
        check("restart_cnt", step_cnt, 16'd0);
        check("restart_dir", step_dir, 2'd1);
        wait_step("restart_wait", 8);
        check("restart_step_dir", step_dir, 2'd1);
        check("restart_step_cnt", step_cnt, 16'd1);
        finish_step(1'b0);

        // AI acknowledges two cycles after the request
        ai_mode = 1'b1;
        wait_ai("ai_req_wait", 8);
        cyc(); cyc();
        check("ai_req_held", ai_req, 1'b1);
        ai_ack = 1'b1; ai_dir = 2'd2; cyc(); ai_ack = 1'b0;
        check("ai_ack_go", step_go, 1'b1);
        check("ai_ack_dir", step_dir, 2'd2);
        check("ai_ack_req_drop", ai_req, 1'b0);
        check("ai_ack_no_tmo", ai_timeout, 1'b0);
        finish_step(1'b0);

        // AI never answers: timeout after 5 request cycles
        wait_ai("ai_req_wait2", 8);
        n = 0;
        while (ai_req && n < 20) begin
            n++;
            cyc();
        end
        check("ai_tmo_req_cycles", n, 5);
        check("ai_tmo_go", step_go, 1'b1);
        check("ai_tmo_pulse", ai_timeout, 1'b1);
        check("ai_tmo_dir", step_dir, 2'd2);
        check("ai_tmo_cnt", step_cnt, 16'd3);
        finish_step(1'b0);

        // AI proposes a reversal: current direction kept
        wait_ai("ai_req_wait3", 8);
        ai_ack = 1'b1; ai_dir = 2'd0; cyc(); ai_ack = 1'b0;
        check("ai_rev_go", step_go, 1'b1);
        check("ai_rev_dir", step_dir, 2'd2);
        finish_step(1'b0);

        // Asynchronous reset during AI request
        wait_ai("ai_req_wait4", 8);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ai_req", ai_req, 1'b0);
        check("arst_running", running, 1'b0);
        check("arst_cnt", step_cnt, 16'd0);
        check("arst_dir", step_dir, 2'd1);
        cyc();
        rst_n = 1'b1; ai_mode = 1'b0;
        no_go_for("no_go_after_arst", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
